// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply and restoring divide on operand magnitudes.
// Signs are applied in FIN. Divide-by-zero and signed overflow skip straight to FIN.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        mul_en,
  input  logic        mul_operation,
  input  logic        div_en,
  input  logic        div_operation,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  state_t      state_next;

  logic        is_mul;
  logic        op_sel;
  logic        neg_result;
  logic        special;
  logic [31:0] special_result;
  logic [5:0]  count;

  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [63:0] product;
  logic [31:0] divisor;
  logic [31:0] rem;
  logic [31:0] quo;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        accept;
  logic        div_zero;
  logic        div_ovf;
  logic        div_special;

  logic [63:0] product_next;
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  logic [63:0] prod_signed;
  logic [31:0] quo_signed;
  logic [31:0] rem_signed;
  logic [31:0] final_result;

  assign busy = (state != IDLE);

  always_comb begin
    a_mag       = operand_a[31] ? (32'd0 - operand_a) : operand_a;
    b_mag       = operand_b[31] ? (32'd0 - operand_b) : operand_b;
    accept      = (state == IDLE) && (mul_en || div_en);
    div_zero    = (operand_b == 32'd0);
    div_ovf     = (operand_a == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
    div_special = !mul_en && div_en && (div_zero || div_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mul_en) begin
          state_next = CALC;
        end else if (div_en) begin
          state_next = div_special ? FIN : CALC;
        end
      end
      CALC: begin
        if (count == 6'd31) begin
          state_next = FIN;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of each algorithm; both advance every CALC cycle, is_mul picks which one matters.
  always_comb begin
    product_next = product + (mplier[0] ? mcand : 64'd0);
    rem_shift    = {rem, quo[31]};
    rem_ge       = (rem_shift >= {1'b0, divisor});
    rem_sub      = rem_shift[31:0] - divisor;
    rem_next     = rem_ge ? rem_sub : rem_shift[31:0];
    quo_next     = {quo[30:0], rem_ge};
  end

  always_comb begin
    prod_signed = neg_result ? (64'd0 - product) : product;
    quo_signed  = neg_result ? (32'd0 - quo) : quo;
    rem_signed  = neg_result ? (32'd0 - rem) : rem;
    if (special) begin
      final_result = special_result;
    end else if (is_mul) begin
      final_result = op_sel ? prod_signed[63:32] : prod_signed[31:0];
    end else begin
      final_result = op_sel ? quo_signed : rem_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result         <= 32'd0;
      valid          <= 1'b0;
      is_mul         <= 1'b0;
      op_sel         <= 1'b0;
      neg_result     <= 1'b0;
      special        <= 1'b0;
      special_result <= 32'd0;
      count          <= 6'd0;
      mcand          <= 64'd0;
      mplier         <= 32'd0;
      product        <= 64'd0;
      divisor        <= 32'd0;
      rem            <= 32'd0;
      quo            <= 32'd0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            is_mul     <= mul_en;
            op_sel     <= mul_en ? mul_operation : div_operation;
            // Remainder takes the dividend's sign; product and quotient take the XOR of both.
            neg_result <= (mul_en || div_operation) ? (operand_a[31] ^ operand_b[31])
                                                    : operand_a[31];
            special    <= div_special;
            if (div_zero) begin
              special_result <= div_operation ? 32'hFFFF_FFFF : operand_a;
            end else begin
              special_result <= div_operation ? 32'h8000_0000 : 32'd0;
            end
            count   <= 6'd0;
            mcand   <= {32'd0, a_mag};
            mplier  <= b_mag;
            product <= 64'd0;
            divisor <= b_mag;
            rem     <= 32'd0;
            quo     <= a_mag;
          end
        end
        CALC: begin
          product <= product_next;
          mcand   <= {mcand[62:0], 1'b0};
          mplier  <= {1'b0, mplier[31:1]};
          rem     <= rem_next;
          quo     <= quo_next;
          count   <= count + 6'd1;
        end
        FIN: begin
          result <= final_result;
          valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
